memory_stage: RTL
=================

# memory_stage

Memory-access stage of the in-order RV32 pipeline, directly downstream of `execute_stage`. It consumes the effective address (`valE`), store data (`valB`) and the decoded memory controls. It runs a single-outstanding request/acknowledge transaction on the data-memory bus and returns load data (`valM`) for write-back. While a transaction is in flight it stalls the upstream stages.

## Interface
- `XLEN`, default 32, datapath width. Only 32 is supported, giving 4 byte lanes.
- `clk`  in  1  pipeline clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  the instruction on the inputs is valid.
- `valE`  in  XLEN  effective address from `execute_stage`.
- `valB`  in  XLEN  store data (rs2 value).
- `mem_read_en`  in  1  the instruction is a load.
- `mem_write_en`  in  1  the instruction is a store.
- `mem_width`  in  2  access width: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `sign_extend`  in  1  load result is sign-extended (1) or zero-extended (0).
- `mem_req`  out  1  bus request; registered.
- `mem_we`  out  1  bus write; registered.
- `mem_addr`  out  XLEN  word-aligned address `{valE[XLEN-1:2],2'b00}`; registered.
- `mem_wdata`  out  XLEN  lane-replicated store data; registered.
- `mem_wstrb`  out  4  byte-lane enables; registered.
- `mem_ack`  in  1  bus completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  XLEN  read data, full word.
- `valM`  out  XLEN  aligned and extended load data.
- `valid_out`  out  1  the result for the current instruction is complete.
- `stall`  out  1  upstream must hold its inputs.
- `misaligned`  out  1  the access was rejected as misaligned or reserved.

## Operation
- A memory op is `valid_in & (mem_read_en | mem_write_en)`. When both enables are set, the instruction is treated as a store.
- A memory op is misaligned, and rejected, when any of these holds:
  - `mem_width` = 01 and `valE[0]` = 1;
  - `mem_width` = 10 and `valE[1:0]` ≠ 0;
  - `mem_width` = 11.
- A rejected op issues no bus request. In the same cycle: `misaligned` = 1, `valid_out` = 1, `stall` = 0, `valM` = 0.
- Non-memory instruction (`valid_in` = 1, no enables): combinational pass-through with `valid_out` = 1, `stall` = 0, `valM` = 0.
- The FSM has three states: IDLE, BUSY, DONE.
  - IDLE → BUSY on an aligned memory op. On that edge it captures `mem_addr`, `mem_we`, `mem_wstrb`, `mem_wdata` and `addr[1:0]`, width and sign, and sets `mem_req` = 1.
  - BUSY → DONE on the edge where `mem_req & mem_ack`. On that edge `mem_req` clears and `valM` is registered from `mem_rdata` (0 for stores).
  - DONE → IDLE unconditionally. In DONE, `valid_out` = 1 and `stall` = 0.
- `stall` = (IDLE & aligned memory op) | BUSY.
- Store lanes, with `a = valE[1:0]`:
  - byte: `wdata = {4{valB[7:0]}}`, `wstrb = 4'b0001 << a`;
  - half: `wdata = {2{valB[15:0]}}`, `wstrb = 4'b0011 << a`;
  - word: `wdata = valB`, `wstrb = 4'b1111`.
- Load data: `r = mem_rdata >> (8*a)`.
  - byte: `valM = ext(r[7:0])`;
  - half: `valM = ext(r[15:0])`;
  - word: `valM = r`.
  - `ext` sign-extends when `sign_extend` = 1, otherwise zero-extends.
- `mem_ack` is ignored outside BUSY. `mem_rdata` is sampled only on an ack in BUSY.

## Timing
- Reset values: state IDLE, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_wstrb` = 0, `valM` = 0. Reset clears these immediately, without waiting for a clock edge.
- Reset in BUSY drops `mem_req` at once. The in-flight transaction is abandoned, and a later `mem_ack` is ignored.
- Latency for an aligned op presented in cycle 0:
  - `mem_req` is high from cycle 1;
  - an ack in cycle k (k ≥ 1) gives DONE with `valid_out` in cycle k+1;
  - minimum latency is 2 cycles, with `stall` high in cycles 0..k.
- Upstream must hold all inputs stable while `stall` = 1. It advances after the DONE cycle.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_wstrb` stay constant from the rising edge of `mem_req` until the ack edge.
- An ack may arrive in the first cycle `mem_req` is high. Only one transaction is outstanding at a time.
- A new op presented in the cycle after DONE is accepted normally, so there is no dead cycle beyond DONE.

## Test plan
- Word load:
  - stimulus: `valE` = 0x100, width 10; ack after 3 cycles with `mem_rdata` = 0xDEADBEEF;
  - response: `mem_addr` = 0x100, `mem_we` = 0, `stall` = 1 for 4 cycles, then `valM` = 0xDEADBEEF with `valid_out` in DONE.
- Signed byte load:
  - stimulus: `valE` = 0x203, `sign_extend` = 1; `mem_rdata` = 0x80112233;
  - response: `valM` = 0xFFFFFF80.
  - Repeat with `sign_extend` = 0; response: `valM` = 0x00000080.
- Half store:
  - stimulus: `valE` = 0x302, `valB` = 0x1234ABCD, width 01;
  - response: `mem_addr` = 0x300, `mem_wdata` = 0xABCDABCD, `mem_wstrb` = 1100, `mem_we` = 1. Bus outputs are held until ack; `valM` = 0.
- Misaligned word:
  - stimulus: `valE` = 0x401, width 10;
  - response: no `mem_req`; same cycle `misaligned` = 1, `valid_out` = 1, `stall` = 0.
  - Same response for width 11.
- Reset mid-transaction and same-cycle ack:
  - stimulus: assert `rst` in BUSY; response: `mem_req` = 0 immediately; a stray `mem_ack` afterwards produces no `valid_out`.
  - stimulus: then a load with ack in the first `mem_req` cycle; response: `valid_out` exactly 2 cycles after presentation.

Source files
------------

// File: rtl/memory_stage.sv
// Memory-access stage of the in-order RV32 pipeline: alignment check, byte-lane store packing,
// one outstanding req/ack data-bus transaction, load-data alignment and sign/zero extension.
// Ports: pipeline inputs (valid_in, valE, valB, memory controls); registered bus master
// (mem_req/we/addr/wdata/wstrb, mem_ack/rdata); results to write-back (valM, valid_out,
// stall, misaligned).
module memory_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [XLEN-1:0] valE,
    input  logic [XLEN-1:0] valB,
    input  logic            mem_read_en,
    input  logic            mem_write_en,
    input  logic [1:0]      mem_width,
    input  logic            sign_extend,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] valM,
    output logic            valid_out,
    output logic            stall,
    output logic            misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            req_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic [1:0]      lane_q;
    logic [1:0]      width_q;
    logic            sext_q;
    logic [XLEN-1:0] valm_q;

    logic            mem_op;
    logic            bad_access;
    logic            accept;
    logic            ack_hit;
    logic [XLEN-1:0] wdata_d;
    logic [3:0]      wstrb_d;
    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] valm_d;

    // Request decode and alignment check.
    always_comb begin
        mem_op     = valid_in & (mem_read_en | mem_write_en);
        bad_access = ((mem_width == 2'b01) & valE[0])
                   | ((mem_width == 2'b10) & (|valE[1:0]))
                   | (mem_width == 2'b11);
        accept     = (state_q == IDLE) & mem_op & ~bad_access;
        // Ack only counts against a live request; a stray ack after reset is dropped.
        ack_hit    = (state_q == BUSY) & req_q & mem_ack;
    end

    // Store data is replicated across lanes so the strobe alone selects the bytes written.
    always_comb begin
        wdata_d = valB;
        wstrb_d = 4'b1111;
        case (mem_width)
            2'b00: begin
                wdata_d = {4{valB[7:0]}};
                wstrb_d = 4'b0001 << valE[1:0];
            end
            2'b01: begin
                wdata_d = {2{valB[15:0]}};
                wstrb_d = 4'b0011 << valE[1:0];
            end
            default: begin
                wdata_d = valB;
                wstrb_d = 4'b1111;
            end
        endcase
    end

    // Load alignment uses the lane/width/sign captured at issue, not the live inputs.
    always_comb begin
        rdata_shifted = mem_rdata >> {lane_q, 3'b000};
        case (width_q)
            2'b00:   load_val = {{(XLEN-8){sext_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'b01:   load_val = {{(XLEN-16){sext_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_val = rdata_shifted;
        endcase
        valm_d = we_q ? '0 : load_val;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        valid_out  = 1'b0;
        stall      = 1'b0;
        misaligned = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (!mem_op) begin
                        valid_out = 1'b1;
                    end else if (bad_access) begin
                        misaligned = 1'b1;
                        valid_out  = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (ack_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_out = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
            lane_q  <= 2'b00;
            width_q <= 2'b00;
            sext_q  <= 1'b0;
            valm_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q   <= 1'b1;
                we_q    <= mem_write_en;
                addr_q  <= {valE[XLEN-1:2], 2'b00};
                wdata_q <= wdata_d;
                wstrb_q <= wstrb_d;
                lane_q  <= valE[1:0];
                width_q <= mem_width;
                sext_q  <= sign_extend;
            end else if (ack_hit) begin
                req_q  <= 1'b0;
                valm_q <= valm_d;
            end
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    // Result is only presented in DONE; rejected and non-memory instructions see zero.
    assign valM      = (state_q == DONE) ? valm_q : '0;

endmodule
